// File: rtl/contador_relogio.sv
`default_nettype none
// ============================================================================
//  Module   : contador_relogio
//  Purpose  : BCD HH:MM:SS time-of-day counter. Samples the 1 Hz square wave
//             from the clock divider in the clk_in domain and advances the
//             time on every tick rising edge. Run/pause control and a manual
//             set mode (per-field increment, no carry between fields) feed
//             the display and decoder stages downstream.
//  Params   : SYNC_STAGES - synchronizer depth on tick_in/set_inc (2..4)
//             MODE_24H    - 1: hours 00..23, 0: hours 12,01..11 with pm flag
//  Ports    : clk_in     - system clock, rising edge
//             reset      - asynchronous active-low reset
//             tick_in    - 1 Hz square wave (asynchronous)
//             run        - 1 advances time, 0 pauses
//             set_en     - 1 selects manual set mode (overrides run)
//             set_sel    - field to set: 00 sec, 01 min, 10 hour, 11 none
//             set_inc    - button, each rising edge bumps the selected field
//             sec_bcd/min_bcd/hour_bcd - two-digit BCD time
//             pm         - PM flag (always 0 in 24h mode)
//             sec_pulse  - one-cycle strobe per time advance
//             carry_day  - one-cycle strobe on day rollover
//  Option   : CONTADOR_ALARM_EN adds alarm_hour_bcd, alarm_min_bcd, alarm_pm
//             inputs and a registered alarm output.
//  Revision : 1.0 - initial release
// ============================================================================
module contador_relogio #(
    parameter int SYNC_STAGES = 2,
    parameter bit MODE_24H    = 1'b1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       run,
    input  logic       set_en,
    input  logic [1:0] set_sel,
    input  logic       set_inc,
`ifdef CONTADOR_ALARM_EN
    input  logic [7:0] alarm_hour_bcd,
    input  logic [7:0] alarm_min_bcd,
    input  logic       alarm_pm,
    output logic       alarm,
`endif
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] hour_bcd,
    output logic       pm,
    output logic       sec_pulse,
    output logic       carry_day
);

    localparam logic [7:0] C_HOUR_LAST  = MODE_24H ? 8'h23 : 8'h12;
    localparam logic [7:0] C_HOUR_FIRST = MODE_24H ? 8'h00 : 8'h01;
    localparam logic [7:0] C_HOUR_RESET = MODE_24H ? 8'h00 : 8'h12;

    typedef enum logic [1:0] {
        ST_PAUSE = 2'd0,
        ST_RUN   = 2'd1,
        ST_SET   = 2'd2
    } state_t;

    // BCD increment: the limit is checked on the whole two-digit value, so
    // the 12h hour field steps 09->10 via the digit carry and 12->01 via wrap.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] last,
                                           input logic [7:0] first);
        if (v == last)
            bcd_inc = first;
        else if (v[3:0] == 4'd9)
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
    endfunction

    // ------------------------------------------------------------------
    // Input synchronizers and rising-edge detectors
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_tick_sync;
    logic [SYNC_STAGES-1:0] r_inc_sync;
    logic                   r_tick_prev;
    logic                   r_inc_prev;
    logic                   w_tick_edge;
    logic                   w_inc_edge;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_tick_sync <= '0;
            r_inc_sync  <= '0;
            r_tick_prev <= 1'b0;
            r_inc_prev  <= 1'b0;
        end else begin
            r_tick_sync <= {r_tick_sync[SYNC_STAGES-2:0], tick_in};
            r_inc_sync  <= {r_inc_sync[SYNC_STAGES-2:0], set_inc};
            r_tick_prev <= r_tick_sync[SYNC_STAGES-1];
            r_inc_prev  <= r_inc_sync[SYNC_STAGES-1];
        end
    end

    assign w_tick_edge = r_tick_sync[SYNC_STAGES-1] & ~r_tick_prev;
    assign w_inc_edge  = r_inc_sync[SYNC_STAGES-1] & ~r_inc_prev;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)
            r_state <= ST_PAUSE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (set_en) begin
            w_state_next = ST_SET;
        end else begin
            case (r_state)
                ST_PAUSE: if (run)  w_state_next = ST_RUN;
                ST_RUN:   if (!run) w_state_next = ST_PAUSE;
                ST_SET:   w_state_next = run ? ST_RUN : ST_PAUSE;
                default:  w_state_next = ST_PAUSE;
            endcase
        end
    end

    // Qualifying with the live set_en level drops a tick that coincides with
    // set_en rising, and a set_inc edge that coincides with set_en falling.
    logic w_advance;
    logic w_set_step;

    assign w_advance  = (r_state == ST_RUN) && run && !set_en && w_tick_edge;
    assign w_set_step = (r_state == ST_SET) && set_en && w_inc_edge;

    // ------------------------------------------------------------------
    // Time count
    // ------------------------------------------------------------------
    logic [7:0] r_sec, r_min, r_hour;
    logic       r_pm, r_pulse, r_carry;
    logic [7:0] w_sec_nxt, w_min_nxt, w_hour_nxt;
    logic       w_pm_nxt, w_pulse_nxt, w_carry_nxt;
    logic [7:0] w_sec_inc, w_min_inc, w_hour_inc;

    assign w_sec_inc  = bcd_inc(r_sec, 8'h59, 8'h00);
    assign w_min_inc  = bcd_inc(r_min, 8'h59, 8'h00);
    assign w_hour_inc = bcd_inc(r_hour, C_HOUR_LAST, C_HOUR_FIRST);

    always_comb begin
        w_sec_nxt   = r_sec;
        w_min_nxt   = r_min;
        w_hour_nxt  = r_hour;
        w_pm_nxt    = r_pm;
        w_pulse_nxt = 1'b0;
        w_carry_nxt = 1'b0;
        if (w_advance) begin
            w_pulse_nxt = 1'b1;
            w_sec_nxt   = w_sec_inc;
            if (r_sec == 8'h59) begin
                w_min_nxt = w_min_inc;
                if (r_min == 8'h59) begin
                    w_hour_nxt = w_hour_inc;
                    if (MODE_24H) begin
                        w_carry_nxt = (r_hour == 8'h23);
                    end else if (r_hour == 8'h11) begin
                        // 11:59:59 -> 12:00:00 flips AM/PM; the day ends at PM
                        w_pm_nxt    = ~r_pm;
                        w_carry_nxt = r_pm;
                    end
                end
            end
        end else if (w_set_step) begin
            case (set_sel)
                2'b00: w_sec_nxt = w_sec_inc;
                2'b01: w_min_nxt = w_min_inc;
                2'b10: begin
                    w_hour_nxt = w_hour_inc;
                    if (!MODE_24H && (r_hour == 8'h11))
                        w_pm_nxt = ~r_pm;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_sec   <= 8'h00;
            r_min   <= 8'h00;
            r_hour  <= C_HOUR_RESET;
            r_pm    <= 1'b0;
            r_pulse <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_sec   <= w_sec_nxt;
            r_min   <= w_min_nxt;
            r_hour  <= w_hour_nxt;
            r_pm    <= w_pm_nxt;
            r_pulse <= w_pulse_nxt;
            r_carry <= w_carry_nxt;
        end
    end

    assign sec_bcd   = r_sec;
    assign min_bcd   = r_min;
    assign hour_bcd  = r_hour;
    assign pm        = r_pm;
    assign sec_pulse = r_pulse;
    assign carry_day = r_carry;

`ifdef CONTADOR_ALARM_EN
    // ------------------------------------------------------------------
    // Alarm: latched on the running advance into the matching HH:MM:00
    // ------------------------------------------------------------------
    logic r_alarm;
    logic w_alarm_hit;

    assign w_alarm_hit = w_advance && (w_sec_nxt == 8'h00) &&
                         (w_hour_nxt == alarm_hour_bcd) &&
                         (w_min_nxt == alarm_min_bcd) &&
                         (MODE_24H || (w_pm_nxt == alarm_pm));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)
            r_alarm <= 1'b0;
        else if (set_en || !run)
            r_alarm <= 1'b0;
        else if (w_alarm_hit)
            r_alarm <= 1'b1;
    end

    assign alarm = r_alarm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_contador_relogio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_contador_relogio
//  Purpose  : Directed self-checking bench for contador_relogio. A 24h and a
//             12h instance share all inputs; expected values are hand-derived.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_contador_relogio;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       tick_in = 1'b0;
    logic       run = 1'b0;
    logic       set_en = 1'b0;
    logic [1:0] set_sel = 2'b11;
    logic       set_inc = 1'b0;

    logic [7:0] sec24, min24, hour24, sec12, min12, hour12;
    logic       pm24, pulse24, carry24, pm12, pulse12, carry12;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    contador_relogio #(.SYNC_STAGES(2), .MODE_24H(1'b1)) dut24 (
        .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .run(run),
        .set_en(set_en), .set_sel(set_sel), .set_inc(set_inc),
        .sec_bcd(sec24), .min_bcd(min24), .hour_bcd(hour24), .pm(pm24),
        .sec_pulse(pulse24), .carry_day(carry24)
    );

    contador_relogio #(.SYNC_STAGES(2), .MODE_24H(1'b0)) dut12 (
        .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .run(run),
        .set_en(set_en), .set_sel(set_sel), .set_inc(set_inc),
        .sec_bcd(sec12), .min_bcd(min12), .hour_bcd(hour12), .pm(pm12),
        .sec_pulse(pulse12), .carry_day(carry12)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic press(input int n);
        for (int i = 0; i < n; i++) begin
            set_inc = 1'b1;
            cycles(4);
            set_inc = 1'b0;
            cycles(4);
        end
    endtask

    task automatic do_tick();
        tick_in = 1'b1;
        cycles(4);
        tick_in = 1'b0;
        cycles(4);
    endtask

    task automatic enter_set();
        set_en = 1'b1;
        cycles(2);
    endtask

    task automatic leave_set(input logic r);
        run    = r;
        set_en = 1'b0;
        cycles(2);
    endtask

    initial begin
        // ---- asynchronous reset, no clock edge needed ----
        #2 reset = 1'b0;
        #1;
        check("rst_sec24", sec24, 8'h00);
        check("rst_min24", min24, 8'h00);
        check("rst_hour24", hour24, 8'h00);
        check("rst_hour12", hour12, 8'h12);
        check("rst_pm12", {7'd0, pm12}, 8'h00);
        check("rst_strobes", {4'd0, pulse24, carry24, pulse12, carry12}, 8'h00);
        cycles(2);
        run   = 1'b1;
        reset = 1'b1;
        cycles(2);

        // ---- first tick: update at the third sampling edge ----
        tick_in = 1'b1;
        cycles(2);
        check("tick1_early_sec", sec24, 8'h00);
        cycles(1);
        tick_in = 1'b0;
        check("tick1_sec", sec24, 8'h01);
        check("tick1_pulse", {7'd0, pulse24}, 8'h01);
        cycles(1);
        check("tick1_pulse_off", {7'd0, pulse24}, 8'h00);
        check("tick1_sec12", sec12, 8'h01);
        cycles(4);

        // ---- set 24h to 23:59:59 (12h lands on 11:59:59 PM) ----
        enter_set();
        set_sel = 2'b00; press(58);
        set_sel = 2'b01; press(59);
        set_sel = 2'b10; press(23);
        check("set_hour24", hour24, 8'h23);
        check("set_min24", min24, 8'h59);
        check("set_sec24", sec24, 8'h59);
        check("set_hour12", hour12, 8'h11);
        check("set_pm12", {7'd0, pm12}, 8'h01);
        leave_set(1'b1);

        tick_in = 1'b1;
        cycles(2);
        check("day_carry_early", {7'd0, carry24}, 8'h00);
        cycles(1);
        tick_in = 1'b0;
        check("day_sec24", sec24, 8'h00);
        check("day_min24", min24, 8'h00);
        check("day_hour24", hour24, 8'h00);
        check("day_strobes24", {6'd0, pulse24, carry24}, 8'h03);
        check("day_hour12", hour12, 8'h12);
        check("day_pm12", {7'd0, pm12}, 8'h00);
        check("day_strobes12", {6'd0, pulse12, carry12}, 8'h03);
        cycles(1);
        check("day_strobes_off", {4'd0, pulse24, carry24, pulse12, carry12}, 8'h00);
        cycles(4);

        // ---- 12h: 11:59:59 AM -> 12:00:00 PM, no day carry ----
        enter_set();
        set_sel = 2'b00; press(59);
        set_sel = 2'b01; press(59);
        set_sel = 2'b10; press(11);
        check("am_hour12", hour12, 8'h11);
        check("am_pm12", {7'd0, pm12}, 8'h00);
        check("am_hour24", hour24, 8'h11);
        leave_set(1'b1);
        tick_in = 1'b1;
        cycles(3);
        tick_in = 1'b0;
        check("noon_hour12", hour12, 8'h12);
        check("noon_min12", min12, 8'h00);
        check("noon_pm12", {7'd0, pm12}, 8'h01);
        check("noon_strobes12", {6'd0, pulse12, carry12}, 8'h02);
        check("noon_hour24", hour24, 8'h12);
        check("noon_carry24", {7'd0, carry24}, 8'h00);
        cycles(4);

        // ---- set minutes with wrap, no carry; ticks ignored in SET ----
        enter_set();
        set_sel = 2'b01; press(59);
        check("setmin_59", min24, 8'h59);
        press(1);
        check("setmin_00", min24, 8'h00);
        check("setmin_hour", hour24, 8'h12);
        press(1);
        check("setmin_01", min24, 8'h01);
        press(1);
        check("setmin_02", min24, 8'h02);
        check("setmin_hour12", hour12, 8'h12);
        do_tick();
        check("set_tick_sec", sec24, 8'h00);
        set_sel = 2'b11; press(1);
        check("sel11_min", min24, 8'h02);
        check("sel11_sec", sec24, 8'h00);

        // ---- pause ignores ticks, then exactly one second on resume ----
        leave_set(1'b0);
        for (int i = 0; i < 5; i++) do_tick();
        check("pause_sec", sec24, 8'h00);
        check("pause_min", min24, 8'h02);
        run = 1'b1;
        cycles(2);
        do_tick();
        check("resume_sec", sec24, 8'h01);
        check("resume_min", min24, 8'h02);
        check("resume_sec12", sec12, 8'h01);

        // ---- async reset mid-strobe at 12:34:56 ----
        enter_set();
        set_sel = 2'b00; press(54);
        set_sel = 2'b01; press(32);
        leave_set(1'b1);
        tick_in = 1'b1;
        cycles(3);
        tick_in = 1'b0;
        check("pre_rst_time", sec24, 8'h56);
        check("pre_rst_min", min24, 8'h34);
        check("pre_rst_pulse", {7'd0, pulse24}, 8'h01);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_sec", sec24, 8'h00);
        check("mid_rst_min", min24, 8'h00);
        check("mid_rst_hour", hour24, 8'h00);
        check("mid_rst_hour12", hour12, 8'h12);
        check("mid_rst_strobes", {4'd0, pulse24, carry24, pulse12, carry12}, 8'h00);
        cycles(2);
        reset = 1'b1;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
